// File: rtl/video_timing_pkg.sv
// ============================================================================
// video_timing_pkg : shared 640x480@60 raster timing and controller states
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W    = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN      = 2'd1;
  localparam state_t ST_STOPPING = 2'd2;

endpackage

`default_nettype wire

// File: rtl/video_timing_ctrl_if.sv
// ============================================================================
// video_timing_ctrl_if : run request in, sync/active/coordinate stream out
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_timing_ctrl_if #(
  parameter int CNT_W = video_timing_pkg::CNT_W
);
  logic             enable;
  logic             hsync;
  logic             vsync;
  logic             video_active;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             frame_start;
  logic             running;

  modport master (
    input  enable,
    output hsync, vsync, video_active, pixel_x, pixel_y, frame_start, running
  );

  modport slave (
    output enable,
    input  hsync, vsync, video_active, pixel_x, pixel_y, frame_start, running
  );
endinterface

`default_nettype wire

// File: rtl/video_timing_ctrl_raster_counter.sv
// ============================================================================
// raster_counter : horizontal/vertical position counters with wrap flags
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter #(
  parameter int H_TOTAL = video_timing_pkg::H_TOTAL,
  parameter int V_TOTAL = video_timing_pkg::V_TOTAL,
  parameter int CNT_W   = video_timing_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             h_last_o,
  output logic             v_last_o
);

  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_last, v_last;

  assign h_last = (h_q == C_H_LAST);
  assign v_last = (v_q == C_V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (clr_i) begin
      h_d = '0;
      v_d = '0;
    end else if (en_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign h_last_o = h_last;
  assign v_last_o = v_last;

endmodule

`default_nettype wire

// File: rtl/video_timing_ctrl.sv
// ============================================================================
// video_timing_ctrl : frame-boundary start/stop raster sequencer with decode
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int H_FP     = video_timing_pkg::H_FP,
  parameter int H_SYNC   = video_timing_pkg::H_SYNC,
  parameter int H_BP     = video_timing_pkg::H_BP,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int V_FP     = video_timing_pkg::V_FP,
  parameter int V_SYNC   = video_timing_pkg::V_SYNC,
  parameter int V_BP     = video_timing_pkg::V_BP,
  parameter int CNT_W    = video_timing_pkg::CNT_W
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  video_timing_ctrl_if.master vt
);

  localparam int LP_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int LP_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] C_H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] C_H_SB  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] C_H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] C_V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] C_V_SB  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] C_V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_last, v_last;
  logic             w_live, w_frame_last, w_vis;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] px_q, px_d;
  logic [CNT_W-1:0] py_q, py_d;
  logic             fs_q, fs_d;
  logic             running_q, running_d;

  assign w_live       = (state_q != ST_IDLE);
  assign w_frame_last = h_last && v_last;

  // Counters are cleared while idle; leaving STOPPING coincides with the natural wrap to 0,0.
  raster_counter #(
    .H_TOTAL (LP_H_TOTAL),
    .V_TOTAL (LP_V_TOTAL),
    .CNT_W   (CNT_W)
  ) u_raster_counter (
    .clk_i    (clk_pixel),
    .rst_ni   (rst_n),
    .en_i     (w_live),
    .clr_i    (!w_live),
    .h_o      (h_cnt),
    .v_o      (v_cnt),
    .h_last_o (h_last),
    .v_last_o (v_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (vt.enable) state_d = ST_RUN;
      ST_RUN:      if (!vt.enable) state_d = ST_STOPPING;
      ST_STOPPING: begin
        if (vt.enable)        state_d = ST_RUN;
        else if (w_frame_last) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  assign w_vis = w_live && (h_cnt < C_H_ACT) && (v_cnt < C_V_ACT);

  always_comb begin
    hsync_d   = !(w_live && (h_cnt >= C_H_SB) && (h_cnt < C_H_SE));
    vsync_d   = !(w_live && (v_cnt >= C_V_SB) && (v_cnt < C_V_SE));
    active_d  = w_vis;
    px_d      = w_vis ? h_cnt : '0;
    py_d      = w_vis ? v_cnt : '0;
    fs_d      = w_live && (h_cnt == '0) && (v_cnt == '0);
    running_d = w_live;
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      active_q  <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      fs_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      px_q      <= px_d;
      py_q      <= py_d;
      fs_q      <= fs_d;
      running_q <= running_d;
    end
  end

  assign vt.hsync        = hsync_q;
  assign vt.vsync        = vsync_q;
  assign vt.video_active = active_q;
  assign vt.pixel_x      = px_q;
  assign vt.pixel_y      = py_q;
  assign vt.frame_start  = fs_q;
  assign vt.running      = running_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
// ============================================================================
// tb_video_timing_ctrl : default-timing and tiny-timing controllers vs a frame model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_ctrl;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
    logic       running;
  } out_t;

  typedef struct {
    bit   rst_n;
    bit   en;
    int   n;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n_l = 1'b0;
  logic rst_n_s = 1'b0;
  int   nchecks = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  video_timing_ctrl_if #(.CNT_W(10)) vif_l ();
  video_timing_ctrl_if #(.CNT_W(10)) vif_s ();

  video_timing_ctrl u_dut_l (
    .clk_pixel (clk),
    .rst_n     (rst_n_l),
    .vt        (vif_l.master)
  );

  video_timing_ctrl #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CNT_W    (10)
  ) u_dut_s (
    .clk_pixel (clk),
    .rst_n     (rst_n_s),
    .vt        (vif_s.master)
  );

  out_t got_l, got_s;
  assign got_l = {vif_l.hsync, vif_l.vsync, vif_l.video_active, vif_l.pixel_x,
                  vif_l.pixel_y, vif_l.frame_start, vif_l.running};
  assign got_s = {vif_s.hsync, vif_s.vsync, vif_s.video_active, vif_s.pixel_x,
                  vif_s.pixel_y, vif_s.frame_start, vif_s.running};

  // Frame model: a raster is either off or at linear pixel index p within the frame.
  int ha[2]  = '{640, 8};
  int hfp[2] = '{16, 2};
  int hs[2]  = '{96, 2};
  int ht[2]  = '{800, 14};
  int va[2]  = '{480, 4};
  int vfp[2] = '{10, 1};
  int vs[2]  = '{2, 1};
  int vt_[2] = '{525, 7};
  bit on[2]   = '{0, 0};
  bit stop[2] = '{0, 0};
  int p[2]    = '{0, 0};

  function automatic out_t mk(bit h, bit v, bit a, int x, int y, bit f, bit r);
    out_t o;
    o.hsync = h; o.vsync = v; o.active = a;
    o.px = 10'(x); o.py = 10'(y); o.fs = f; o.running = r;
    return o;
  endfunction

  task automatic model_step(input int d, input bit rst, input bit en, output out_t e);
    int h, v, ft;
    bit last;
    ft = ht[d] * vt_[d];
    e = mk(1, 1, 0, 0, 0, 0, 0);
    if (!rst) begin
      on[d] = 0; stop[d] = 0; p[d] = 0;
    end else begin
      if (on[d]) begin
        h = p[d] % ht[d];
        v = p[d] / ht[d];
        e.hsync   = !(h >= ha[d] + hfp[d] && h < ha[d] + hfp[d] + hs[d]);
        e.vsync   = !(v >= va[d] + vfp[d] && v < va[d] + vfp[d] + vs[d]);
        e.active  = (h < ha[d]) && (v < va[d]);
        e.px      = e.active ? 10'(h) : 10'd0;
        e.py      = e.active ? 10'(v) : 10'd0;
        e.fs      = (p[d] == 0);
        e.running = 1'b1;
        last = (p[d] == ft - 1);
        p[d] = (p[d] + 1) % ft;
        if (stop[d]) begin
          if (en) stop[d] = 0;
          else if (last) on[d] = 0;
        end else if (!en) begin
          stop[d] = 1;
        end
      end else if (en) begin
        on[d] = 1; stop[d] = 0; p[d] = 0;
      end
    end
  endtask

  task automatic check_out(input string name, input out_t got, input out_t exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got hs=%b vs=%b act=%b x=%0d y=%0d fs=%b run=%b exp hs=%b vs=%b act=%b x=%0d y=%0d fs=%b run=%b",
               name, $time, got.hsync, got.vsync, got.active, got.px, got.py, got.fs, got.running,
               exp.hsync, exp.vsync, exp.active, exp.px, exp.py, exp.fs, exp.running);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    nchecks++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, exp);
    end
  endtask

  out_t exp_l, exp_s;
  always @(posedge clk) begin
    model_step(0, rst_n_l, vif_l.enable, exp_l);
    model_step(1, rst_n_s, vif_s.enable, exp_s);
    #1;
    check_out("model_l", got_l, exp_l);
    check_out("model_s", got_s, exp_s);
  end

  // Independent hsync width/period measurement on the full-size raster.
  int  cyc = 0;
  int  low_run = 0;
  int  last_fall = -1;
  bit  prev_hs = 1'b1;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!vif_l.running) begin
      low_run = 0; last_fall = -1; prev_hs = 1'b1;
    end else begin
      if (!vif_l.hsync) begin
        if (prev_hs) begin
          if (last_fall >= 0) check_int("hsync_period", cyc - last_fall, 800);
          last_fall = cyc;
        end
        low_run++;
      end else if (low_run > 0) begin
        check_int("hsync_width", low_run, 96);
        low_run = 0;
      end
      prev_hs = vif_l.hsync;
    end
  end

  vec_t tbl[18];

  initial begin
    vif_l.enable = 1'b0;
    vif_s.enable = 1'b0;

    tbl[0]  = '{0, 0, 2,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 1, 1,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 1, 1,  mk(1, 1, 1, 0, 0, 1, 1)};
    tbl[3]  = '{1, 1, 1,  mk(1, 1, 1, 1, 0, 0, 1)};
    tbl[4]  = '{1, 1, 8,  mk(1, 1, 0, 0, 0, 0, 1)};
    tbl[5]  = '{1, 1, 1,  mk(0, 1, 0, 0, 0, 0, 1)};
    tbl[6]  = '{1, 1, 2,  mk(1, 1, 0, 0, 0, 0, 1)};
    tbl[7]  = '{1, 1, 17, mk(1, 1, 1, 1, 2, 0, 1)};
    tbl[8]  = '{1, 1, 41, mk(1, 0, 0, 0, 0, 0, 1)};
    tbl[9]  = '{1, 1, 27, mk(1, 1, 0, 0, 0, 0, 1)};
    tbl[10] = '{1, 1, 1,  mk(1, 1, 1, 0, 0, 1, 1)};
    tbl[11] = '{1, 0, 1,  mk(1, 1, 1, 1, 0, 0, 1)};
    tbl[12] = '{1, 0, 96, mk(1, 1, 0, 0, 0, 0, 1)};
    tbl[13] = '{1, 0, 1,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[14] = '{1, 0, 5,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[15] = '{1, 1, 2,  mk(1, 1, 1, 0, 0, 1, 1)};
    tbl[16] = '{1, 0, 3,  mk(1, 1, 1, 3, 0, 0, 1)};
    tbl[17] = '{1, 1, 200, mk(1, 1, 1, 7, 0, 0, 1)};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst_n_s      = tbl[i].rst_n;
      vif_s.enable = tbl[i].en;
      repeat (tbl[i].n) @(posedge clk);
      #2;
      check_out($sformatf("tbl%0d", i), got_s, tbl[i].exp);
    end

    // Random run/stop/reset traffic on the tiny raster, scored by the frame model.
    for (int seg = 0; seg < 40; seg++) begin
      @(negedge clk);
      rst_n_s      = ($urandom_range(0, 19) != 0);
      vif_s.enable = $urandom_range(0, 1);
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end

    // Full-size raster: run to h=300,v=50, pulse reset, then relaunch.
    @(negedge clk);
    rst_n_l      = 1'b1;
    vif_l.enable = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!(on[0] && p[0] == 50 * 800 + 300) && guard < 50000) begin
        @(negedge clk);
        guard++;
      end
      check_int("reach_h300_v50", guard < 50000 ? 1 : 0, 1);
    end
    rst_n_l = 1'b0;
    @(posedge clk); #2;
    check_out("mid_reset", got_l, mk(1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n_l = 1'b1;
    @(posedge clk); #2;
    check_out("relaunch_idle", got_l, mk(1, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #2;
    check_out("relaunch_fs", got_l, mk(1, 1, 1, 0, 0, 1, 1));
    @(posedge clk); #2;
    check_out("relaunch_x1", got_l, mk(1, 1, 1, 1, 0, 0, 1));
    repeat (2000) @(posedge clk);
    @(negedge clk);
    vif_l.enable = 1'b0;
    vif_s.enable = 1'b0;
    repeat (3) @(posedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

`default_nettype wire
